// File: rtl/fir_stream_pkg.sv
// Shared constants, types and width helpers for the FIR stream driver.
package fir_stream_pkg;

  // Bit positions inside the sticky error vector
  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_FLUSH = 1;

  typedef logic [1:0] fir_err_t;

  // Pointer width for a power-of-two FIFO; never below one bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width able to hold the values 0..depth inclusive
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush and occupancy counter.
module sync_fifo_fwft
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd,
  input  logic                          flush,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    level
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_rd;
  logic              do_wr;

  // A write into a full FIFO is only legal when the head leaves in the same cycle
  always_comb begin
    do_rd = rd & ~empty & ~flush;
    do_wr = wr & ~flush & (~full | do_rd);
  end

  // Pointer and occupancy bookkeeping; flush behaves like a local reset
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since reads are qualified by empty
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Head of queue is visible without a read request
  always_comb begin
    rd_data = mem[rd_ptr];
    empty   = (count == '0);
    full    = (count == LVL_W'(DEPTH));
    level   = count;
  end

endmodule

// File: rtl/fir_stream_driver.sv
// Source selector, enable gate and FWFT buffer feeding the FIR filter.
module fir_stream_driver
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned DEPTH           = 8,
  parameter bit          FLUSH_ON_SWITCH = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [$clog2(NUM_SRC)-1:0]    iter_sel,
  input  logic                          iter_enable,
  input  logic                          err_clear,
  output logic [DATA_W-1:0]             fir_data,
  output logic                          fir_valid,
  input  logic                          fir_ready,
  output logic [1:0]                    fir_error,
  output logic [$clog2(DEPTH+1)-1:0]    fill_level,
  output logic [CNT_W-1:0]              sample_count
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam int unsigned LVL_W = level_width(DEPTH);

  logic [SEL_W-1:0]  sel_next_c;
  logic [SEL_W-1:0]  sel_q;
  logic              flush_q;
  logic              wr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              pop_c;
  logic              ovf_c;
  logic              flush_err_c;
  fir_err_t          err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;

  // Out-of-range selects fold onto source 0 before being registered
  always_comb begin
    sel_next_c = (32'(iter_sel) < NUM_SRC) ? iter_sel : '0;
  end

  // Registered select; a change schedules a one-cycle flush when enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      sel_q   <= sel_next_c;
      flush_q <= FLUSH_ON_SWITCH && (sel_next_c != sel_q);
    end
  end

  // Write path follows the registered select only; handshake is masked during flush
  always_comb begin
    wr_data_c   = src_data[32'(sel_q) * DATA_W +: DATA_W];
    wr_c        = src_valid[sel_q] & iter_enable & ~flush_q;
    pop_c       = ~fifo_empty & ~flush_q & fir_ready;
    ovf_c       = wr_c & fifo_full & ~pop_c;
    flush_err_c = flush_q & (fifo_level != '0);
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr      (wr_c),
    .wr_data (wr_data_c),
    .rd      (fir_ready),
    .flush   (flush_q),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  // Sticky error bits; a new event in the clear cycle keeps the bit set
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q[ERR_OVF]   <= (err_q[ERR_OVF]   & ~err_clear) | ovf_c;
      err_q[ERR_FLUSH] <= (err_q[ERR_FLUSH] & ~err_clear) | flush_err_c;
    end
  end

  // Completed-handshake counter, wraps freely
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (pop_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Output view; data reads as zero whenever nothing is offered
  always_comb begin
    fir_valid    = ~fifo_empty & ~flush_q;
    fir_data     = fir_valid ? fifo_rd_data : '0;
    fir_error    = err_q;
    fill_level   = fifo_level;
    sample_count = cnt_q;
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Scoreboard bench: instance A (3 sources, flush on switch), instance B (2 sources, no flush).
module tb_fir_stream_driver;

  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [3*DW-1:0] a_src_data;
  logic [2:0]      a_src_valid;
  logic [1:0]      a_iter_sel;
  logic            a_iter_enable, a_err_clear, a_fir_ready;
  logic [DW-1:0]   a_fir_data;
  logic            a_fir_valid;
  logic [1:0]      a_fir_error;
  logic [3:0]      a_fill_level;
  logic [31:0]     a_sample_count;

  logic [2*DW-1:0] b_src_data;
  logic [1:0]      b_src_valid;
  logic [0:0]      b_iter_sel;
  logic            b_iter_enable, b_err_clear, b_fir_ready;
  logic [DW-1:0]   b_fir_data;
  logic            b_fir_valid;
  logic [1:0]      b_fir_error;
  logic [3:0]      b_fill_level;
  logic [31:0]     b_sample_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];

  fir_stream_driver #(.DATA_W(16), .NUM_SRC(3), .DEPTH(8), .FLUSH_ON_SWITCH(1'b1), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .src_data(a_src_data), .src_valid(a_src_valid),
    .iter_sel(a_iter_sel), .iter_enable(a_iter_enable), .err_clear(a_err_clear),
    .fir_data(a_fir_data), .fir_valid(a_fir_valid), .fir_ready(a_fir_ready),
    .fir_error(a_fir_error), .fill_level(a_fill_level), .sample_count(a_sample_count)
  );

  fir_stream_driver #(.DATA_W(16), .NUM_SRC(2), .DEPTH(8), .FLUSH_ON_SWITCH(1'b0), .CNT_W(32)) dut_b (
    .clock(clock), .reset(reset), .src_data(b_src_data), .src_valid(b_src_valid),
    .iter_sel(b_iter_sel), .iter_enable(b_iter_enable), .err_clear(b_err_clear),
    .fir_data(b_fir_data), .fir_valid(b_fir_valid), .fir_ready(b_fir_ready),
    .fir_error(b_fir_error), .fill_level(b_fill_level), .sample_count(b_sample_count)
  );

  // Output monitors: each handshake pops the oldest expected sample
  always @(negedge clock) begin : mon_a
    logic [DW-1:0] e;
    if (!reset && a_fir_valid && a_fir_ready) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_output: got %h, required no output", a_fir_data);
      end else begin
        e = a_q.pop_front();
        if (a_fir_data !== e) begin
          errors++;
          $display("FAIL a_output_data: got %h, required %h", a_fir_data, e);
        end
      end
    end
  end

  always @(negedge clock) begin : mon_b
    logic [DW-1:0] e;
    if (!reset && b_fir_valid && b_fir_ready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_output: got %h, required no output", b_fir_data);
      end else begin
        e = b_q.pop_front();
        if (b_fir_data !== e) begin
          errors++;
          $display("FAIL b_output_data: got %h, required %h", b_fir_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a_src(input int idx, input logic [DW-1:0] d);
    a_src_data[idx*DW +: DW] = d;
  endtask

  task automatic set_b_src(input int idx, input logic [DW-1:0] d);
    b_src_data[idx*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_src_data = '0; a_src_valid = '0; a_iter_sel = '0;
    a_iter_enable = 1'b0; a_err_clear = 1'b0; a_fir_ready = 1'b0;
    b_src_data = '0; b_src_valid = '0; b_iter_sel = '0;
    b_iter_enable = 1'b0; b_err_clear = 1'b0; b_fir_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    a_q.delete();
    b_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_fir_valid !== 1'b0 || a_fir_data !== 16'h0) begin
      errors++; $display("FAIL reset_out: got valid=%b data=%h, required 0/0000", a_fir_valid, a_fir_data);
    end
    checks++;
    if (a_fir_error !== 2'b00 || a_fill_level !== 4'd0 || a_sample_count !== 32'd0) begin
      errors++; $display("FAIL reset_status: got err=%b fill=%0d cnt=%0d, required 0/0/0", a_fir_error, a_fill_level, a_sample_count);
    end
    a_iter_enable = 1'b1;
    step();
    checks++;
    if (a_fir_valid !== 1'b0 || b_fir_valid !== 1'b0) begin
      errors++; $display("FAIL reset_first_cycle: got a=%b b=%b, required 0/0", a_fir_valid, b_fir_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    a_iter_enable = 1'b1; a_fir_ready = 1'b1;
    set_a_src(0, 16'h1234); a_src_valid = 3'b001; a_q.push_back(16'h1234);
    step();
    a_src_valid = '0;
    checks++;
    if (a_fir_valid !== 1'b1 || a_fir_data !== 16'h1234) begin
      errors++; $display("FAIL single_latency: got valid=%b data=%h, required 1/1234", a_fir_valid, a_fir_data);
    end
    step();
    checks++;
    if (a_sample_count !== 32'd1 || a_fill_level !== 4'd0 || a_fir_valid !== 1'b0) begin
      errors++; $display("FAIL single_after: got cnt=%0d fill=%0d valid=%b, required 1/0/0", a_sample_count, a_fill_level, a_fir_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    a_iter_enable = 1'b1; a_fir_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_a_src(0, 16'(i)); a_src_valid = 3'b001;
      if (i <= 8) a_q.push_back(16'(i));
      step();
    end
    a_src_valid = '0;
    checks++;
    if (a_fill_level !== 4'd8 || a_fir_error !== 2'b01) begin
      errors++; $display("FAIL ovf_full: got fill=%0d err=%b, required 8/01", a_fill_level, a_fir_error);
    end
    checks++;
    if (a_fir_valid !== 1'b1 || a_fir_data !== 16'd1) begin
      errors++; $display("FAIL ovf_head_stable: got valid=%b data=%h, required 1/0001", a_fir_valid, a_fir_data);
    end
    a_fir_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (a_sample_count !== 32'd8 || a_fill_level !== 4'd0 || a_q.size() != 0) begin
      errors++; $display("FAIL ovf_drain: got cnt=%0d fill=%0d left=%0d, required 8/0/0", a_sample_count, a_fill_level, a_q.size());
    end
    a_fir_ready = 1'b0; a_err_clear = 1'b1;
    step();
    a_err_clear = 1'b0;
    checks++;
    if (a_fir_error !== 2'b00) begin
      errors++; $display("FAIL ovf_clear: got err=%b, required 00", a_fir_error);
    end
    for (int i = 0; i < 8; i++) begin
      set_a_src(0, 16'(16'h20 + i)); a_src_valid = 3'b001; a_q.push_back(16'(16'h20 + i));
      step();
    end
    set_a_src(0, 16'h28); a_err_clear = 1'b1;
    step();
    a_src_valid = '0; a_err_clear = 1'b0;
    checks++;
    if (a_fir_error !== 2'b01) begin
      errors++; $display("FAIL ovf_set_wins: got err=%b, required 01", a_fir_error);
    end
    a_fir_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (a_q.size() != 0 || a_fill_level !== 4'd0) begin
      errors++; $display("FAIL ovf_redrain: got left=%0d fill=%0d, required 0/0", a_q.size(), a_fill_level);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    a_iter_enable = 1'b1; a_fir_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_a_src(0, 16'(16'h100 + i)); a_src_valid = 3'b001; a_q.push_back(16'(16'h100 + i));
      step();
    end
    set_a_src(0, 16'h108); a_q.push_back(16'h108); a_fir_ready = 1'b1;
    step();
    a_src_valid = '0;
    checks++;
    if (a_fill_level !== 4'd8 || a_fir_error !== 2'b00) begin
      errors++; $display("FAIL full_pop: got fill=%0d err=%b, required 8/00", a_fill_level, a_fir_error);
    end
    repeat (8) step();
    checks++;
    if (a_sample_count !== 32'd9 || a_fill_level !== 4'd0 || a_q.size() != 0) begin
      errors++; $display("FAIL full_pop_drain: got cnt=%0d fill=%0d left=%0d, required 9/0/0", a_sample_count, a_fill_level, a_q.size());
    end
  endtask

  task automatic test_flush_switch();
    do_reset();
    a_iter_enable = 1'b1; a_fir_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_a_src(0, 16'(16'hA0 + i)); a_src_valid = 3'b001;
      step();
    end
    a_src_valid = '0;
    checks++;
    if (a_fill_level !== 4'd3) begin
      errors++; $display("FAIL flush_prefill: got fill=%0d, required 3", a_fill_level);
    end
    a_iter_sel = 2'd1;
    step();
    step();
    checks++;
    if (a_fill_level !== 4'd0 || a_fir_error !== 2'b10 || a_fir_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got fill=%0d err=%b valid=%b, required 0/10/0", a_fill_level, a_fir_error, a_fir_valid);
    end
    set_a_src(1, 16'hB1); a_src_valid = 3'b010; a_q.push_back(16'hB1);
    step();
    a_src_valid = '0;
    checks++;
    if (a_fir_valid !== 1'b1 || a_fir_data !== 16'hB1) begin
      errors++; $display("FAIL flush_next: got valid=%b data=%h, required 1/00b1", a_fir_valid, a_fir_data);
    end
    a_fir_ready = 1'b1;
    step();
    checks++;
    if (a_sample_count !== 32'd1 || a_q.size() != 0) begin
      errors++; $display("FAIL flush_count: got cnt=%0d left=%0d, required 1/0", a_sample_count, a_q.size());
    end
  endtask

  task automatic test_no_flush_switch();
    do_reset();
    b_iter_enable = 1'b1; b_fir_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_b_src(0, 16'(16'hA0 + i)); b_src_valid = 2'b01; b_q.push_back(16'(16'hA0 + i));
      step();
    end
    b_src_valid = '0; b_iter_sel = 1'b1;
    step();
    for (int i = 1; i <= 2; i++) begin
      set_b_src(1, 16'(16'hB0 + i)); b_src_valid = 2'b10; b_q.push_back(16'(16'hB0 + i));
      step();
    end
    b_src_valid = '0;
    checks++;
    if (b_fill_level !== 4'd5 || b_fir_error !== 2'b00) begin
      errors++; $display("FAIL noflush_fill: got fill=%0d err=%b, required 5/00", b_fill_level, b_fir_error);
    end
    b_fir_ready = 1'b1;
    repeat (5) step();
    checks++;
    if (b_sample_count !== 32'd5 || b_fir_error !== 2'b00 || b_q.size() != 0) begin
      errors++; $display("FAIL noflush_drain: got cnt=%0d err=%b left=%0d, required 5/00/0", b_sample_count, b_fir_error, b_q.size());
    end
  endtask

  task automatic test_gating_and_range();
    do_reset();
    a_iter_enable = 1'b0;
    set_a_src(0, 16'h5555); a_src_valid = 3'b001;
    repeat (4) step();
    a_src_valid = '0;
    checks++;
    if (a_fill_level !== 4'd0 || a_fir_valid !== 1'b0) begin
      errors++; $display("FAIL gate_disabled: got fill=%0d valid=%b, required 0/0", a_fill_level, a_fir_valid);
    end
    a_iter_sel = 2'd3; a_iter_enable = 1'b1; a_fir_ready = 1'b1;
    set_a_src(0, 16'h0C0D); set_a_src(1, 16'hEE01); set_a_src(2, 16'hEE02);
    a_src_valid = 3'b111; a_q.push_back(16'h0C0D);
    step();
    a_src_valid = '0;
    checks++;
    if (a_fir_valid !== 1'b1 || a_fir_data !== 16'h0C0D) begin
      errors++; $display("FAIL range_sel: got valid=%b data=%h, required 1/0c0d", a_fir_valid, a_fir_data);
    end
    step();
    step();
    set_a_src(0, 16'h0C0E); a_src_valid = 3'b111; a_q.push_back(16'h0C0E);
    step();
    a_src_valid = '0;
    checks++;
    if (a_fir_valid !== 1'b1 || a_fir_data !== 16'h0C0E) begin
      errors++; $display("FAIL range_steady: got valid=%b data=%h, required 1/0c0e", a_fir_valid, a_fir_data);
    end
    step();
    checks++;
    if (a_sample_count !== 32'd2 || a_fir_error !== 2'b00 || a_q.size() != 0) begin
      errors++; $display("FAIL range_final: got cnt=%0d err=%b left=%0d, required 2/00/0", a_sample_count, a_fir_error, a_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_flush_switch();
    test_no_flush_switch();
    test_gating_and_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
